// File: rtl/convolution_coprocessor_y_loader.sv
// Stream-fed Y-sample loader for the convolution coprocessor: captures a length byte
// and that many samples, pulses start, then waits for cop_done before taking the next frame.
module convolution_coprocessor_y_loader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned MAX_SIZE   = 31
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [ADDR_WIDTH-1:0] memY_addr,
  output logic [DATA_WIDTH-1:0] dataY,
  output logic [ADDR_WIDTH-1:0] sizeY,
  output logic                  start,
  input  logic                  cop_done,
  output logic                  loader_busy,
  output logic                  len_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]   size_q, size_d;
  logic                    len_err_q, len_err_d;
  logic                    ready_q, ready_d;
  logic                    start_q, start_d;
  logic                    busy_q, busy_d;

  logic                    accept;
  logic                    len_ok;
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   mem_q [0:DEPTH-1];

  assign accept = s_valid && ready_q;
  // Range check uses the full byte; only then is it narrowed to ADDR_WIDTH.
  assign len_ok = (s_data != '0) && (32'(s_data) <= MAX_SIZE);

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    size_d    = size_q;
    len_err_d = 1'b0;
    mem_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (len_ok) begin
            size_d   = s_data[ADDR_WIDTH-1:0];
            wr_ptr_d = '0;
            state_d  = S_LOAD;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
          if (wr_ptr_q == size_q - ADDR_WIDTH'(1)) begin
            state_d = S_START;
          end
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (cop_done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Status outputs are registered from the next state so they are all 0 while in reset.
    ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
    start_d = (state_d == S_START);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      size_q    <= '0;
      len_err_q <= 1'b0;
      ready_q   <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      size_q    <= size_d;
      len_err_q <= len_err_d;
      ready_q   <= ready_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
    end
  end

  // Sample memory is deliberately not reset; contents survive reset and later frames.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  assign dataY       = mem_q[memY_addr];
  assign sizeY       = size_q;
  assign s_ready     = ready_q;
  assign start       = start_q;
  assign loader_busy = busy_q;
  assign len_err     = len_err_q;

endmodule

// File: tb/tb_convolution_coprocessor_y_loader.sv
// Directed self-checking bench for convolution_coprocessor_y_loader.
module tb_convolution_coprocessor_y_loader;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [4:0] memY_addr;
  logic [7:0] dataY;
  logic [4:0] sizeY;
  logic       start;
  logic       cop_done;
  logic       loader_busy;
  logic       len_err;

  int total = 0;
  int bad   = 0;

  convolution_coprocessor_y_loader #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(5),
    .MAX_SIZE  (31)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .memY_addr  (memY_addr),
    .dataY      (dataY),
    .sizeY      (sizeY),
    .start      (start),
    .cop_done   (cop_done),
    .loader_busy(loader_busy),
    .len_err    (len_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] exp);
    memY_addr = a;
    #1;
    chk("dataY", 32'(dataY), 32'(exp));
  endtask

  task automatic done_pulse();
    cop_done = 1'b1;
    step();
    cop_done = 1'b0;
    chk("idle_ready", 32'(s_ready), 1);
    chk("idle_busy", 32'(loader_busy), 0);
  endtask

  initial begin
    rstn = 1'b0; s_data = '0; s_valid = 1'b0; memY_addr = '0; cop_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(s_ready), 0);
    chk("rst_start", 32'(start), 0);
    chk("rst_busy", 32'(loader_busy), 0);
    chk("rst_len_err", 32'(len_err), 0);
    chk("rst_sizeY", 32'(sizeY), 0);
    rstn = 1'b1;
    step();
    chk("ready_after_rst", 32'(s_ready), 1);

    // Test 1 + 4: frame {3: 10 20 30}, then bytes offered while in WAIT.
    s_valid = 1'b1; s_data = 8'd3;
    step();
    chk("t1_sizeY", 32'(sizeY), 3);
    chk("t1_busy", 32'(loader_busy), 1);
    chk("t1_ready0", 32'(s_ready), 1);
    chk("t1_start0", 32'(start), 0);
    s_data = 8'd10; step(); chk("t1_ready1", 32'(s_ready), 1); chk("t1_start1", 32'(start), 0);
    s_data = 8'd20; step(); chk("t1_ready2", 32'(s_ready), 1); chk("t1_start2", 32'(start), 0);
    s_data = 8'd30; step();
    chk("t1_start", 32'(start), 1);
    chk("t1_ready_drop", 32'(s_ready), 0);
    s_data = 8'd2;
    step();
    chk("t1_start_once", 32'(start), 0);
    chk("t1_wait_ready", 32'(s_ready), 0);
    chk("t1_wait_busy", 32'(loader_busy), 1);
    step(); step();
    chk("t4_wait_ready", 32'(s_ready), 0);
    chk("t4_sizeY_held", 32'(sizeY), 3);
    chk("t4_no_start", 32'(start), 0);
    rd(5'd0, 8'd10); rd(5'd1, 8'd20); rd(5'd2, 8'd30);
    done_pulse();
    chk("t4_sizeY_not_taken", 32'(sizeY), 3);
    step();
    chk("t4_new_len", 32'(sizeY), 2);
    chk("t4_new_busy", 32'(loader_busy), 1);
    s_data = 8'd50; step();
    s_data = 8'd51; step();
    chk("t4_start", 32'(start), 1);
    s_valid = 1'b0;
    step();
    done_pulse();

    // Test 2: rejected lengths 0 and 40.
    s_valid = 1'b1; s_data = 8'd0;
    step();
    chk("t2_len_err0", 32'(len_err), 1);
    chk("t2_sizeY0", 32'(sizeY), 2);
    chk("t2_busy0", 32'(loader_busy), 0);
    chk("t2_start0", 32'(start), 0);
    s_data = 8'd40;
    step();
    chk("t2_len_err40", 32'(len_err), 1);
    chk("t2_busy40", 32'(loader_busy), 0);
    chk("t2_ready40", 32'(s_ready), 1);
    s_valid = 1'b0;
    step();
    chk("t2_len_err_clear", 32'(len_err), 0);
    chk("t2_sizeY_kept", 32'(sizeY), 2);
    chk("t2_no_start", 32'(start), 0);

    // Test 3: maximum length frame with s_valid toggling every cycle.
    s_valid = 1'b1; s_data = 8'd31;
    step();
    chk("t3_sizeY", 32'(sizeY), 31);
    for (int i = 1; i <= 31; i++) begin
      s_valid = 1'b1; s_data = 8'(i);
      step();
      chk("t3_start_on", 32'(start), (i == 31) ? 1 : 0);
      s_valid = 1'b0;
      step();
      chk("t3_start_off", 32'(start), 0);
    end
    chk("t3_wait_ready", 32'(s_ready), 0);
    rd(5'd0, 8'd1); rd(5'd15, 8'd16); rd(5'd30, 8'd31);
    done_pulse();

    // Test 5: frame {3: 5 6 7}, including a read of the address being written.
    s_valid = 1'b1; s_data = 8'd3;
    step();
    memY_addr = 5'd0; s_data = 8'd5;
    #1;
    chk("t5_old_value", 32'(dataY), 1);
    step();
    chk("t5_new_value", 32'(dataY), 5);
    s_data = 8'd6; step();
    s_data = 8'd7; step();
    chk("t5_start", 32'(start), 1);
    s_valid = 1'b0;
    rd(5'd0, 8'd5); rd(5'd1, 8'd6); rd(5'd2, 8'd7);
    step();
    done_pulse();

    // Test 6: reset in the middle of a 5-byte frame after two samples.
    s_valid = 1'b1; s_data = 8'd5; step();
    s_data = 8'd90; step();
    s_data = 8'd91; step();
    s_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_ready", 32'(s_ready), 0);
    chk("t6_busy", 32'(loader_busy), 0);
    chk("t6_sizeY", 32'(sizeY), 0);
    chk("t6_start", 32'(start), 0);
    chk("t6_len_err", 32'(len_err), 0);
    #1;
    rstn = 1'b1;
    step();
    chk("t6_ready_back", 32'(s_ready), 1);
    chk("t6_no_start", 32'(start), 0);
    s_valid = 1'b1; s_data = 8'd1; step();
    s_data = 8'd77; step();
    chk("t6_start", 32'(start), 1);
    s_valid = 1'b0;
    rd(5'd0, 8'd77); rd(5'd1, 8'd91); rd(5'd2, 8'd7);
    step();
    done_pulse();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
